fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: requests one word at a time, hands it to decode and
// waits for branch/jump resolution when needed. Define FETCH_CTRL_PERF_EN for the stall counter.
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        dec_ready,
    input  logic        tgt_valid,
    input  logic        b_taken,
    input  logic [31:0] tgt_addr,
    output logic [31:0] stall_cnt
);

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        RESP,
        ISSUE,
        RESOLVE
    } state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t      state;
    logic [31:0] pc;
    logic        is_ctrl;
    logic        is_uncond;

    assign imem_addr = pc;
    assign is_uncond = (inst[6:0] == OP_JAL) || (inst[6:0] == OP_JALR);
    assign is_ctrl   = is_uncond || (inst[6:0] == OP_BRANCH);

    // NOTE: state and registered outputs use non-blocking assignments under an async
    // active-low reset so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            imem_req   <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_gnt) begin
                        imem_req <= 1'b0;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    if (imem_rvalid) begin
                        inst    <= imem_rdata;
                        inst_pc <= pc;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // First ISSUE cycle loads the word; inst_valid shows from the next one.
                    if (!inst_valid) begin
                        inst_valid <= 1'b1;
                    end else if (dec_ready) begin
                        inst_valid <= 1'b0;
                        if (is_ctrl) begin
                            state <= RESOLVE;
                        end else begin
                            pc       <= pc + 32'd4;
                            imem_req <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                RESOLVE: begin
                    if (tgt_valid) begin
                        if (is_uncond || b_taken) begin
                            pc <= {tgt_addr[31:2], 2'b00};
                        end else begin
                            pc <= inst_pc + 32'd4;
                        end
                        imem_req <= 1'b1;
                        state    <= REQ;
                    end
                end
                default: begin
                    state      <= BOOT;
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic stall_now;

    always_comb begin
        stall_now = 1'b0;
        case (state)
            REQ:     stall_now = !imem_gnt;
            RESP:    stall_now = !imem_rvalid;
            ISSUE:   stall_now = !dec_ready;
            RESOLVE: stall_now = !tgt_valid;
            default: stall_now = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_cnt <= 32'h0;
        end else if (stall_now && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed fetch/branch/stall/wrap/reset scenarios, then random
// memory and decode behaviour, all checked against a transaction-level fetch model.
module tb_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;
`ifdef FETCH_CTRL_PERF_EN
    localparam logic [31:0] STALL5 = 32'd5;
`else
    localparam logic [31:0] STALL5 = 32'd0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        dec_ready = 1'b0;
    logic        tgt_valid = 1'b0;
    logic        b_taken = 1'b0;
    logic [31:0] tgt_addr = 32'h0;
    logic [31:0] stall_cnt;

    fetch_ctrl #(.RESET_VECTOR(RV)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .dec_ready  (dec_ready),
        .tgt_valid  (tgt_valid),
        .b_taken    (b_taken),
        .tgt_addr   (tgt_addr),
        .stall_cnt  (stall_cnt)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cnt = 0;

    // stimulus knobs
    int          p_gnt = 100, p_rvalid = 100, p_ready = 100, p_tgt = 100;
    int          b_mode = 0;
    bit          rand_data = 0;
    logic [31:0] fix_rdata = 32'h0000_0013;
    logic [31:0] fix_tgt = 32'h0;
    int          stall_left = 0;

    // reference model: what the fetch unit owes its neighbours, per transaction
    logic [31:0] m_pc, m_inst, m_inst_pc, m_out_pc, m_stall;
    bit          m_boot, m_fetch_due, m_out, m_load, m_iv, m_pend, iv_prev;
    int          rises[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  ops [6];
        ops[0] = 7'b0010011; ops[1] = 7'b0110011; ops[2] = 7'b1101111;
        ops[3] = 7'b1100111; ops[4] = 7'b1100011; ops[5] = 7'b0000011;
        r = $urandom;
        return {r[31:7], ops[$urandom_range(5)]};
    endfunction

    task automatic model_reset();
        m_pc = RV; m_boot = 1; m_fetch_due = 0; m_out = 0; m_load = 0;
        m_iv = 0; m_pend = 0; m_stall = 0; iv_prev = 0;
        m_inst = 0; m_inst_pc = 0; m_out_pc = 0;
        rises.delete();
    endtask

    task automatic drive();
        imem_gnt    = ($urandom_range(99) < p_gnt);
        imem_rvalid = ($urandom_range(99) < p_rvalid);
        imem_rdata  = rand_data ? rand_inst() : fix_rdata;
        dec_ready   = ($urandom_range(99) < p_ready);
        if (stall_left > 0 && inst_valid) begin
            dec_ready = 1'b0;
            stall_left--;
        end
        tgt_valid = ($urandom_range(99) < p_tgt);
        b_taken   = (b_mode == 2) ? 1'($urandom_range(1)) : 1'(b_mode);
        tgt_addr  = rand_data ? $urandom : fix_tgt;
    endtask

    // Checks the outputs seen now, then predicts the effect of the coming rising edge.
    task automatic model_eval();
        logic [6:0] op;
        bit         taken;
        if (inst_valid && !iv_prev) rises.push_back(cyc);
        iv_prev = inst_valid;
        check("imem_req", {31'b0, imem_req}, {31'b0, m_fetch_due});
        if (m_fetch_due) check("imem_addr", imem_addr, m_pc);
        check("inst_valid", {31'b0, inst_valid}, {31'b0, m_iv});
        if (m_iv) begin
            check("inst", inst, m_inst);
            check("inst_pc", inst_pc, m_inst_pc);
        end
        check("stall_cnt", stall_cnt, m_stall);
`ifdef FETCH_CTRL_PERF_EN
        if (((m_fetch_due && !imem_gnt) || (m_out && !imem_rvalid) ||
             ((m_load || m_iv) && !dec_ready) || (m_pend && !tgt_valid)) &&
            (m_stall != 32'hFFFF_FFFF))
            m_stall = m_stall + 1;
`endif
        op = m_inst[6:0];
        if (m_boot) begin
            m_boot = 0;
            m_fetch_due = 1;
        end else if (m_fetch_due && imem_gnt) begin
            m_fetch_due = 0;
            m_out = 1;
            m_out_pc = m_pc;
        end else if (m_out && imem_rvalid) begin
            m_out = 0;
            m_inst = imem_rdata;
            m_inst_pc = m_out_pc;
            m_load = 1;
        end else if (m_load) begin
            m_load = 0;
            m_iv = 1;
        end else if (m_iv && dec_ready) begin
            m_iv = 0;
            hs_cnt++;
            if (op == 7'b1101111 || op == 7'b1100111 || op == 7'b1100011) begin
                m_pend = 1;
            end else begin
                m_pc = m_inst_pc + 4;
                m_fetch_due = 1;
            end
        end else if (m_pend && tgt_valid) begin
            m_pend = 0;
            taken = (op == 7'b1101111) || (op == 7'b1100111) || b_taken;
            m_pc = taken ? (tgt_addr & 32'hFFFF_FFFC) : m_inst_pc + 4;
            m_fetch_due = 1;
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
        drive();
        model_eval();
    endtask

    task automatic expect_req(input logic [31:0] exp, input string tag);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (imem_req) begin
                seen = 1;
                check(tag, imem_addr, exp);
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Asserts reset between edges, checks the outputs at once, then releases after a posedge.
    task automatic apply_reset(input string tag);
        #2 RESET = 1'b0;
        #1;
        check({tag, "_req"}, {31'b0, imem_req}, 32'd0);
        check({tag, "_addr"}, imem_addr, RV);
        check({tag, "_inst"}, inst, 32'd0);
        check({tag, "_inst_pc"}, inst_pc, 32'd0);
        check({tag, "_iv"}, {31'b0, inst_valid}, 32'd0);
        check({tag, "_stall"}, stall_cnt, 32'd0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        apply_reset("por");

        // back-to-back straight-line fetches with an ideal memory and decoder
        expect_req(32'h0, "fetch0");
        expect_req(32'h4, "fetch4");
        expect_req(32'h8, "fetch8");
        fix_rdata = 32'h0000_0063; b_mode = 0; fix_tgt = 32'h100;
        expect_req(32'hC, "br_not_taken");
        check("iv_rises", rises.size(), 32'd3);
        if (rises.size() >= 3) begin
            check("iv_gap_a", rises[1] - rises[0], 32'd4);
            check("iv_gap_b", rises[2] - rises[1], 32'd4);
        end
        b_mode = 1;
        expect_req(32'h100, "br_taken");
        fix_rdata = 32'h0000_0067; b_mode = 0; fix_tgt = 32'h203;
        expect_req(32'h200, "jalr_target");

        // decode back-pressure for five cycles while the word is presented
        fix_rdata = 32'h0000_0013; stall_left = 5;
        expect_req(32'h204, "after_stall");
        check("stall_five", stall_cnt, STALL5);

        // jump to the top of the address space, then wrap
        fix_rdata = 32'h0000_006F; fix_tgt = 32'hFFFF_FFFF;
        expect_req(32'hFFFF_FFFC, "jal_top");
        fix_rdata = 32'h0000_0013;
        expect_req(32'h0, "pc_wrap");

        // reset while waiting for a response
        p_rvalid = 0;
        tick();
        check("in_resp_req", {31'b0, imem_req}, 32'd0);
        apply_reset("resp_rst");
        p_rvalid = 100;
        expect_req(RV, "refetch");

        // random memory latency, decode back-pressure, branches and noise
        rand_data = 1; b_mode = 2;
        p_gnt = 60; p_rvalid = 55; p_ready = 60; p_tgt = 45;
        hs_cnt = 0;
        repeat (2500) tick();
        apply_reset("rand_rst");
        repeat (2500) tick();
        check("rand_progress", {31'b0, hs_cnt > 200}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
